test_session_ctrl: RTL
======================

TEST_SESSION_CTRL -- requirements
Module: test_session_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of generator/checker port pairs sequenced.
REQ-002 The block SHALL have parameter TIMER_WIDTH, default 32, giving the duration/elapsed counter width.
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 1024, giving the cycles between generator stop and checker stop (minimum 1).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- cfg_port_mask  in  NUM_PORTS  ports taking part in the session.
- cfg_duration  in  TIMER_WIDTH  run length in clk cycles.
- cmd_start  in  1  single-cycle session start request.
- cmd_abort  in  1  single-cycle abort request.
- gen_ready  in  NUM_PORTS  per-port generator idle/ready.
- chk_ready  in  NUM_PORTS  per-port checker ready.
- gen_start  out  NUM_PORTS  one-cycle generator start pulses.
- gen_stop  out  NUM_PORTS  one-cycle generator stop pulses.
- chk_start  out  NUM_PORTS  one-cycle checker start (clears checker results).
- chk_stop  out  NUM_PORTS  one-cycle checker stop pulses.
- busy  out  1  session in progress (state not IDLE/DONE).
- done  out  1  last session completed; held until next accepted start.
- aborted  out  1  last session ended by abort; valid while done=1.
- elapsed  out  TIMER_WIDTH  cycles spent in RUN in current/last session.

Function
REQ-005 The state machine SHALL have states IDLE, WAIT_RDY, ARM, LAUNCH, RUN, STOP_GEN, DRAIN, STOP_CHK, DONE.
REQ-006 In IDLE or DONE, cmd_start with cfg_port_mask!=0 and cfg_duration!=0 SHALL be accepted: latch mask and duration, clear done/aborted/elapsed, enter WAIT_RDY next cycle; otherwise cmd_start SHALL be ignored.
REQ-007 Configuration inputs SHALL be sampled only at accepted start; later changes SHALL have no effect on the running session.
REQ-008 WAIT_RDY SHALL advance to ARM when (gen_ready & chk_ready & mask) == mask, and SHALL wait indefinitely otherwise.
REQ-009 ARM SHALL last exactly one cycle, with chk_start = mask; LAUNCH SHALL follow for exactly one cycle, with gen_start = mask.
REQ-010 RUN SHALL increment elapsed by 1 per cycle starting from 0, and SHALL move to STOP_GEN on the cycle elapsed reaches duration-1, so RUN lasts exactly duration cycles and elapsed ends at duration.
REQ-011 elapsed SHALL saturate at all-ones and never wrap.
REQ-012 STOP_GEN SHALL last one cycle, with gen_stop = mask, then enter DRAIN.
REQ-013 DRAIN SHALL last exactly DRAIN_CYCLES cycles, then enter STOP_CHK.
REQ-014 STOP_CHK SHALL last one cycle, with chk_stop = mask, then enter DONE, with done=1.
REQ-015 Bits of gen_*/chk_* outputs for unmasked ports SHALL be 0 at all times; all pulses SHALL be registered outputs.
REQ-016 cmd_abort SHALL be handled as follows:
- in WAIT_RDY or ARM: go to DONE with aborted=1 and no gen_stop/chk_stop issued; ARM's chk_start still completes if ARM is the current cycle.
- in LAUNCH or RUN: go to STOP_GEN next cycle with aborted=1, then follow the normal drain and stop sequence.
- in STOP_GEN, DRAIN or STOP_CHK: set aborted=1 and leave the sequence unchanged.
- in IDLE or DONE: ignore.
REQ-017 If cmd_start and cmd_abort are both asserted, abort SHALL take priority when busy, and start SHALL win when not busy.
REQ-018 cmd_start while busy SHALL be ignored.

Reset
REQ-019 On rst assertion, the block SHALL asynchronously enter IDLE with all outputs 0: pulses, busy, done, aborted, elapsed; latched mask/duration SHALL be cleared.
REQ-020 Reset mid-session SHALL emit no stop pulses; the downstream checker/generator SHALL be reset by the same rst.
REQ-021 Release of rst SHALL be synchronous to clk; the first command SHALL be accepted on the first rising edge after deassertion.

Verification
REQ-022 Nominal: mask=4'b0101, duration=10, DRAIN_CYCLES=4, all ready -> the bench SHALL check:
- chk_start=0101 at cycle t+2 and gen_start=0101 at t+3;
- gen_stop=0101 exactly 10 cycles later, chk_stop=0101 after 4 further cycles;
- done=1, aborted=0, elapsed=10.
REQ-023 Ready gating: chk_ready[2]=0 for 20 cycles with mask=0100 -> no start pulses until one cycle after chk_ready[2] rises.
REQ-024 Abort in RUN at elapsed=3 (duration=100) -> the bench SHALL check:
- gen_stop on the next cycle, then drain, then chk_stop;
- done=1, aborted=1, elapsed=4.
REQ-025 Illegal start: mask=0 or duration=0 -> the state SHALL stay IDLE with no pulses; cmd_start during RUN SHALL not disturb the counter.
REQ-026 Async reset during DRAIN -> all outputs SHALL read 0 before the next clk edge, with no chk_stop pulse; a new start after release SHALL complete normally.
REQ-027 Saturation: TIMER_WIDTH=4, duration=15 -> elapsed SHALL end at 15 with no wrap; back-to-back session from DONE SHALL clear elapsed to 0.

Source files
------------

// File: rtl/test_session_ctrl.sv
// Test session sequencer: waits for ready, arms checkers, launches generators, runs for a
// programmed duration, stops generators, drains, then stops checkers.
module test_session_ctrl #(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned TIMER_WIDTH  = 32,
    parameter int unsigned DRAIN_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   cfg_port_mask,
    input  logic [TIMER_WIDTH-1:0] cfg_duration,
    input  logic                   cmd_start,
    input  logic                   cmd_abort,
    input  logic [NUM_PORTS-1:0]   gen_ready,
    input  logic [NUM_PORTS-1:0]   chk_ready,
    output logic [NUM_PORTS-1:0]   gen_start,
    output logic [NUM_PORTS-1:0]   gen_stop,
    output logic [NUM_PORTS-1:0]   chk_start,
    output logic [NUM_PORTS-1:0]   chk_stop,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [TIMER_WIDTH-1:0] elapsed
);

    localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [3:0] {
        StIdle, StWaitRdy, StArm, StLaunch, StRun, StStopGen, StDrain, StStopChk, StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_PORTS-1:0]   mask_q, mask_d;
    logic [TIMER_WIDTH-1:0] dur_q, dur_d;
    logic [TIMER_WIDTH-1:0] elapsed_q, elapsed_d;
    logic [DrainW-1:0]      drain_q, drain_d;
    logic                   aborted_q, aborted_d;
    logic [NUM_PORTS-1:0]   gen_start_q, gen_start_d;
    logic [NUM_PORTS-1:0]   gen_stop_q, gen_stop_d;
    logic [NUM_PORTS-1:0]   chk_start_q, chk_start_d;
    logic [NUM_PORTS-1:0]   chk_stop_q, chk_stop_d;

    logic start_ok;
    logic all_rdy;

    assign start_ok = cmd_start && (cfg_port_mask != '0) && (cfg_duration != '0);
    assign all_rdy  = ((gen_ready & chk_ready & mask_q) == mask_q);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        dur_d     = dur_q;
        elapsed_d = elapsed_q;
        drain_d   = drain_q;
        aborted_d = aborted_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    state_d   = StWaitRdy;
                    mask_d    = cfg_port_mask;
                    dur_d     = cfg_duration;
                    elapsed_d = '0;
                    aborted_d = 1'b0;
                end
            end
            StWaitRdy: begin
                if (cmd_abort) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end else if (all_rdy) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                if (cmd_abort) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end else begin
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                if (cmd_abort) begin
                    state_d   = StStopGen;
                    aborted_d = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (elapsed_q != '1) begin
                    elapsed_d = elapsed_q + TIMER_WIDTH'(1);
                end
                if (cmd_abort) begin
                    state_d   = StStopGen;
                    aborted_d = 1'b1;
                end else if (elapsed_q == dur_q - TIMER_WIDTH'(1)) begin
                    state_d = StStopGen;
                end
            end
            StStopGen: begin
                aborted_d = aborted_q | cmd_abort;
                drain_d   = DrainW'(DRAIN_CYCLES - 1);
                state_d   = StDrain;
            end
            StDrain: begin
                aborted_d = aborted_q | cmd_abort;
                if (drain_q == '0) begin
                    state_d = StStopChk;
                end else begin
                    drain_d = drain_q - DrainW'(1);
                end
            end
            StStopChk: begin
                aborted_d = aborted_q | cmd_abort;
                state_d   = StDone;
            end
            default: state_d = StIdle;
        endcase

        // Pulses are registered: decode the state being entered, gated by the latched mask.
        chk_start_d = (state_d == StArm)     ? mask_d : '0;
        gen_start_d = (state_d == StLaunch)  ? mask_d : '0;
        gen_stop_d  = (state_d == StStopGen) ? mask_d : '0;
        chk_stop_d  = (state_d == StStopChk) ? mask_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            dur_q       <= '0;
            elapsed_q   <= '0;
            drain_q     <= '0;
            aborted_q   <= 1'b0;
            gen_start_q <= '0;
            gen_stop_q  <= '0;
            chk_start_q <= '0;
            chk_stop_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            dur_q       <= dur_d;
            elapsed_q   <= elapsed_d;
            drain_q     <= drain_d;
            aborted_q   <= aborted_d;
            gen_start_q <= gen_start_d;
            gen_stop_q  <= gen_stop_d;
            chk_start_q <= chk_start_d;
            chk_stop_q  <= chk_stop_d;
        end
    end

    assign gen_start = gen_start_q;
    assign gen_stop  = gen_stop_q;
    assign chk_start = chk_start_q;
    assign chk_stop  = chk_stop_q;
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign done      = (state_q == StDone);
    assign aborted   = aborted_q;
    assign elapsed   = elapsed_q;

endmodule
